// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage pipeline control slice.
//   pctl_state_t      : sequencing controller state (RUN / DRAIN / HALTED)
//   PCTL_DRAIN_CYCLES : cycles to retire EX, MEM and WB after a halt
// ---------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pctl_state_t;

  localparam int unsigned PCTL_DRAIN_CYCLES = 3;

endpackage

// File: rtl/pipeline_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_unit
// Combinational load-use hazard detection between the EX and ID stages.
// Ports:
//   ld_ex, ex_rw            in  : EX instruction is a load / writes the RF
//   ex_rd                   in  : EX destination register
//   id_rs, id_rt            in  : ID source registers
//   id_use_rs, id_use_rt    in  : ID instruction really reads rs / rt
//   lu                      out : load-use hazard, ID must wait one cycle
// ---------------------------------------------------------------------------
module pipeline_hazard_unit (
  input  logic       ld_ex,
  input  logic       ex_rw,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       lu
);

  logic ex_loads_reg;
  logic rs_match;
  logic rt_match;

  // $0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign ex_loads_reg = ld_ex && ex_rw && (ex_rd != 5'd0);
  assign rs_match     = id_use_rs && (id_rs == ex_rd);
  assign rt_match     = id_use_rt && (id_rt == ex_rd);
  assign lu           = ex_loads_reg && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central sequencing controller for the 5-stage pipeline. Generates the
// load-enable / synchronous-clear of PC, IF/ID, ID/EX, EX/MEM, MEM/WB and
// resolves load-use stalls, taken-branch flushes, data-memory waits and the
// halt / drain / resume sequence. Keeps cycle, stall and flush counters.
// Ports:
//   clk, rst (sync, active-low)
//   ld_ex, ex_rw, ex_rd, id_rs, id_rt, id_use_rs, id_use_rt : hazard inputs
//   br_taken_ex, halt_id, mem_wait, go                      : control inputs
//   pc_en, ifid_en, idex_en, exmem_en, memwb_en             : register loads
//   ifid_clr, idex_clr, exmem_clr, memwb_clr                : bubble inserts
//   halted                                                  : in HALTED
//   cyc_cnt, stall_cnt, flush_cnt                           : perf counters
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = PCTL_DRAIN_CYCLES,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_ex,
  input  logic             ex_rw,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             br_taken_ex,
  input  logic             halt_id,
  input  logic             mem_wait,
  input  logic             go,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic             memwb_clr,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);

  pctl_state_t      state_q;
  pctl_state_t      state_n;
  logic [DCW-1:0]   drain_q;
  logic             halted_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic lu;
  logic run_freeze;
  logic run_flush;
  logic run_lu;
  logic run_halt;
  logic drain_last;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  pipeline_hazard_unit u_hazard (
    .ld_ex     (ld_ex),
    .ex_rw     (ex_rw),
    .ex_rd     (ex_rd),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .lu        (lu)
  );

  // RUN-state priority decode: freeze > flush > load-use > halt.
  always_comb begin
    run_freeze = 1'b0;
    run_flush  = 1'b0;
    run_lu     = 1'b0;
    run_halt   = 1'b0;
    if (state_q == RUN) begin
      if (mem_wait)         run_freeze = 1'b1;
      else if (br_taken_ex) run_flush  = 1'b1;
      else if (lu)          run_lu     = 1'b1;
      else if (halt_id)     run_halt   = 1'b1;
    end
  end

  // Last unfrozen DRAIN cycle: EX/MEM/WB retire on this edge.
  assign drain_last = (state_q == DRAIN) && !mem_wait && (drain_q == DCW'(1));

  // State / drain counter / halted / performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
      cyc_q    <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_n;
      halted_q <= (state_n == HALTED);
      cyc_q    <= cnt_inc(cyc_q);
      if (run_freeze || run_lu) stall_q <= cnt_inc(stall_q);
      if (run_flush)            flush_q <= cnt_inc(flush_q);
      if (run_halt)
        drain_q <= DCW'(DRAIN_CYCLES);
      else if ((state_q == DRAIN) && !mem_wait)
        drain_q <= drain_q - DCW'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      RUN:     if (run_halt)   state_n = DRAIN;
      DRAIN:   if (drain_last) state_n = HALTED;
      HALTED:  if (go)         state_n = RUN;
      default:                 state_n = RUN;
    endcase
  end

  // Enable / clear decode; reset forces every register to load zero.
  always_comb begin
    pc_en     = 1'b0;
    ifid_en   = 1'b0;
    idex_en   = 1'b0;
    exmem_en  = 1'b0;
    memwb_en  = 1'b0;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    memwb_clr = 1'b0;
    if (!rst) begin
      pc_en     = 1'b1;
      ifid_en   = 1'b1;
      idex_en   = 1'b1;
      exmem_en  = 1'b1;
      memwb_en  = 1'b1;
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
      memwb_clr = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (run_flush) begin
            // Squash the two younger wrong-path slots (IF and ID).
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
          end else if (run_lu || run_halt) begin
            // Hold PC and IF/ID, push a bubble into EX.
            idex_en  = 1'b1;
            idex_clr = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end else if (!run_freeze) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
        DRAIN: begin
          if (!mem_wait) begin
            idex_en  = 1'b1;
            idex_clr = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
        HALTED: begin
          // Resume: fetch past the halt; ID still holds the halt, so bubble it.
          if (go) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            idex_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign halted    = halted_q;
  assign cyc_cnt   = cyc_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl: directed scenarios plus a randomized
// run compared against a behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int CNT_W = 32;
  localparam int DRAIN = 3;

  logic clk = 1'b0;
  logic rst;
  logic ld_ex, ex_rw, id_use_rs, id_use_rt, br_taken_ex, halt_id, mem_wait, go;
  logic [4:0] ex_rd, id_rs, id_rt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_clr, idex_clr, exmem_clr, memwb_clr;
  logic halted;
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;

  logic [8:0] ctl;
  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_clr, idex_clr, exmem_clr, memwb_clr};

  localparam logic [8:0] C_RESET  = 9'b11111_1111;
  localparam logic [8:0] C_NORMAL = 9'b11111_0000;
  localparam logic [8:0] C_FREEZE = 9'b00000_0000;
  localparam logic [8:0] C_BUBBLE = 9'b00111_0100;
  localparam logic [8:0] C_FLUSH  = 9'b11111_1100;
  localparam logic [8:0] C_RESUME = 9'b11111_0100;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode 0 = running, 1 = draining, 2 = halted.
  int               m_mode = 0;
  int               m_left = 0;
  logic [CNT_W-1:0] m_cyc = '0, m_stall = '0, m_flush = '0;
  logic             m_halted = 1'b0;

  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ld_ex(ld_ex), .ex_rw(ex_rw), .ex_rd(ex_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .br_taken_ex(br_taken_ex), .halt_id(halt_id), .mem_wait(mem_wait), .go(go),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
    .exmem_clr(exmem_clr), .memwb_clr(memwb_clr), .halted(halted),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic ref_lu();
    if (!(ld_ex && ex_rw) || ex_rd == 5'd0) return 1'b0;
    return (id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd);
  endfunction

  function automatic logic [8:0] ref_ctl();
    if (!rst) return C_RESET;
    if (m_mode == 0) begin
      if (mem_wait)               return C_FREEZE;
      if (br_taken_ex)            return C_FLUSH;
      if (ref_lu() || halt_id)    return C_BUBBLE;
      return C_NORMAL;
    end
    if (m_mode == 1) return mem_wait ? C_FREEZE : C_BUBBLE;
    return go ? C_RESUME : C_FREEZE;
  endfunction

  // Advance the model with the current inputs, then let the clock edge pass.
  task automatic tick();
    if (!rst) begin
      m_mode = 0; m_left = 0; m_cyc = '0; m_stall = '0; m_flush = '0;
    end else begin
      m_cyc = m_cyc + 1;
      if (m_mode == 0) begin
        if (mem_wait)         m_stall = m_stall + 1;
        else if (br_taken_ex) m_flush = m_flush + 1;
        else if (ref_lu())    m_stall = m_stall + 1;
        else if (halt_id) begin m_mode = 1; m_left = DRAIN; end
      end else if (m_mode == 1) begin
        if (!mem_wait) begin
          if (m_left == 1) m_mode = 2;
          m_left = m_left - 1;
        end
      end else if (go) begin
        m_mode = 0;
      end
    end
    m_halted = (m_mode == 2);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b1; ld_ex = 0; ex_rw = 0; ex_rd = 0; id_rs = 0; id_rt = 0;
    id_use_rs = 0; id_use_rt = 0; br_taken_ex = 0; halt_id = 0; mem_wait = 0; go = 0;
  endtask

  task automatic test_reset();
    set_idle(); rst = 1'b0; #3;
    n_checks++;
    if (ctl !== C_RESET) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RESET); end
    tick();
    n_checks++;
    if ({halted, cyc_cnt, stall_cnt, flush_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_state: halted %b cyc %0d stall %0d flush %0d want all 0",
                         halted, cyc_cnt, stall_cnt, flush_cnt);
    end
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    logic [CNT_W-1:0] s0;
    set_idle(); ld_ex = 1; ex_rw = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1; #3;
    n_checks++;
    if (ctl !== C_BUBBLE) begin n_fail++; $display("FAIL lu_stall_ctl: got %b want %b", ctl, C_BUBBLE); end
    s0 = m_stall;
    tick();
    n_checks++;
    if (stall_cnt !== s0 + 1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, s0 + 1); end
    set_idle(); id_rs = 5; id_use_rs = 1; #3;
    n_checks++;
    if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL lu_release_ctl: got %b want %b", ctl, C_NORMAL); end
    tick();
  endtask

  task automatic test_no_stall();
    set_idle(); ld_ex = 1; ex_rw = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1; #3;
    n_checks++;
    if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL lu_zero_reg: got %b want %b", ctl, C_NORMAL); end
    tick();
    set_idle(); ex_rw = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1; #3;
    n_checks++;
    if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL nonload_no_stall: got %b want %b", ctl, C_NORMAL); end
    tick();
    set_idle(); ld_ex = 1; ex_rw = 1; ex_rd = 7; id_rt = 7; id_use_rt = 1; #3;
    n_checks++;
    if (ctl !== C_BUBBLE) begin n_fail++; $display("FAIL lu_rt_stall: got %b want %b", ctl, C_BUBBLE); end
    tick();
  endtask

  task automatic test_branch_priority();
    logic [CNT_W-1:0] f0;
    set_idle(); br_taken_ex = 1; halt_id = 1;
    ld_ex = 1; ex_rw = 1; ex_rd = 9; id_rs = 9; id_use_rs = 1; #3;
    n_checks++;
    if (ctl !== C_FLUSH) begin n_fail++; $display("FAIL branch_ctl: got %b want %b", ctl, C_FLUSH); end
    f0 = m_flush;
    tick();
    n_checks++;
    if (flush_cnt !== f0 + 1) begin n_fail++; $display("FAIL branch_flush_cnt: got %0d want %0d", flush_cnt, f0 + 1); end
    set_idle(); #3;
    n_checks++;
    if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL branch_stays_run: got %b want %b", ctl, C_NORMAL); end
    tick();
  endtask

  task automatic test_mem_wait();
    logic [CNT_W-1:0] s0;
    s0 = m_stall;
    set_idle(); mem_wait = 1;
    for (int i = 0; i < 4; i++) begin
      #3;
      n_checks++;
      if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL memwait_freeze[%0d]: got %b want %b", i, ctl, C_FREEZE); end
      tick();
    end
    n_checks++;
    if (stall_cnt !== s0 + 4) begin n_fail++; $display("FAIL memwait_stall_cnt: got %0d want %0d", stall_cnt, s0 + 4); end
    set_idle();
  endtask

  task automatic test_halt_drain();
    set_idle(); halt_id = 1; #3;
    n_checks++;
    if (ctl !== C_BUBBLE) begin n_fail++; $display("FAIL halt_detect_ctl: got %b want %b", ctl, C_BUBBLE); end
    tick();
    // Cycles t+1..t+5: drain, two frozen, drain, drain.
    for (int c = 1; c <= 5; c++) begin
      set_idle(); go = 1; mem_wait = (c == 2 || c == 3); #3;
      n_checks++;
      if (ctl !== (mem_wait ? C_FREEZE : C_BUBBLE)) begin
        n_fail++; $display("FAIL drain_ctl[t+%0d]: got %b want %b", c, ctl, mem_wait ? C_FREEZE : C_BUBBLE);
      end
      n_checks++;
      if (halted !== 1'b0) begin n_fail++; $display("FAIL drain_halted_early[t+%0d]: got %b want 0", c, halted); end
      tick();
    end
    set_idle(); #3;
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halted_at_t6: got %b want 1", halted); end
    n_checks++;
    if (ctl !== C_FREEZE) begin n_fail++; $display("FAIL halted_ctl: got %b want %b", ctl, C_FREEZE); end
    tick();
    go = 1; #3;
    n_checks++;
    if (ctl !== C_RESUME) begin n_fail++; $display("FAIL resume_ctl: got %b want %b", ctl, C_RESUME); end
    tick();
    set_idle(); #3;
    n_checks++;
    if (halted !== 1'b0 || ctl !== C_NORMAL) begin
      n_fail++; $display("FAIL resume_run: halted %b ctl %b want 0 %b", halted, ctl, C_NORMAL);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    set_idle(); halt_id = 1; #3; tick();
    set_idle(); #3; tick();
    rst = 1'b0; #3;
    n_checks++;
    if (ctl !== C_RESET) begin n_fail++; $display("FAIL drain_reset_ctl: got %b want %b", ctl, C_RESET); end
    tick();
    n_checks++;
    if ({halted, cyc_cnt, stall_cnt, flush_cnt} !== '0) begin
      n_fail++; $display("FAIL drain_reset_state: halted %b cyc %0d stall %0d flush %0d want all 0",
                         halted, cyc_cnt, stall_cnt, flush_cnt);
    end
    set_idle(); #3;
    n_checks++;
    if (ctl !== C_NORMAL) begin n_fail++; $display("FAIL drain_reset_run: got %b want %b", ctl, C_NORMAL); end
    tick();
    n_checks++;
    if (cyc_cnt !== 1) begin n_fail++; $display("FAIL drain_reset_cyc: got %0d want 1", cyc_cnt); end
  endtask

  task automatic test_random();
    logic [8:0] exp_ctl;
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(0, 59) != 0);
      ld_ex       = 1'($urandom_range(0, 1));
      ex_rw       = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_use_rs   = 1'($urandom_range(0, 1));
      id_use_rt   = 1'($urandom_range(0, 1));
      br_taken_ex = ($urandom_range(0, 7) == 0);
      halt_id     = ($urandom_range(0, 9) == 0);
      mem_wait    = ($urandom_range(0, 4) == 0);
      go          = ($urandom_range(0, 3) == 0);
      #3;
      exp_ctl = ref_ctl();
      n_checks++;
      if (ctl !== exp_ctl) begin n_fail++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, ctl, exp_ctl); end
      tick();
      n_checks++;
      if (halted !== m_halted || cyc_cnt !== m_cyc || stall_cnt !== m_stall || flush_cnt !== m_flush) begin
        n_fail++;
        $display("FAIL rand_regs[%0d]: got h%b c%0d s%0d f%0d want h%b c%0d s%0d f%0d", i,
                 halted, cyc_cnt, stall_cnt, flush_cnt, m_halted, m_cyc, m_stall, m_flush);
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_priority();
    test_mem_wait();
    test_halt_drain();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
